decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  Instruction decode (ID) pipeline stage of the RV32 core. Takes one fetched instruction and its PC
//  over a valid/ready handshake, and decodes opcode, register indices, immediate and integer-EX config.
//  Registers the result into a single pipeline register that feeds the integer execution stage.
//  Supports downstream back-pressure and a one-cycle flush from branch/jump resolution.
// PARAMETERS
//  PC_W    `pc_size (32)          PC width
//  INSTR_W `instr_size (32)       instruction width
//  DATA_W  `data_size (32)        immediate / operand width
//  RA_W    `regfile_logsize (5)   register index width
// PORTS
//  clk           in   1       core clock, all state on rising edge
//  rst_n         in   1       asynchronous active-low reset
//  flush         in   1       kill the held and incoming instruction
//  in_valid      in   1       fetch presents instr/pc
//  in_ready      out  1       stage accepts this cycle
//  in_instr      in   INSTR_W raw instruction
//  in_pc         in   PC_W    instruction PC
//  out_valid     out  1       decoded bundle valid
//  out_ready     in   1       EX stage accepts bundle
//  out_pc        out  PC_W    registered PC
//  out_rs1/rs2   out  RA_W    source register indices (0 when unused)
//  out_rd        out  RA_W    destination index (0 when reg_write=0)
//  out_imm       out  DATA_W  sign-extended immediate
//  out_conf      out  3       iexu_conf for EX
//  out_use_imm   out  1       operand B = imm
//  out_reg_write out  1       writes rd
//  out_is_load/is_branch/is_jump/is_system out 1 each  class flags
//  out_illegal   out  1       unsupported encoding; all side-effect flags forced to 0
// BEHAVIOUR
//  - Reset: out_valid=0, all out_* = 0, out_conf=add_conf. in_ready is 1 out of reset.
//  - in_ready = !out_valid || out_ready (combinational). Transfer in when in_valid&&in_ready.
//  - Latency: 1 cycle; out_* updates only on an input transfer and stays stable while out_valid && !out_ready.
//  - out_valid next: flush -> 0; else input transfer -> 1; else out_valid && out_ready -> 0; else hold.
//  - Flush has priority over a same-cycle input transfer; the incoming instruction is dropped.
//  - Simultaneous out_ready and in_valid: the bundle is replaced in the same edge with no bubble (full throughput).
//  - rtype_op: conf from funct3/funct7. 000 gives add, or sub when funct7=0100000. 001 sll, 100 xor.
//    101 gives srl, or sra when funct7=0100000. 110 or, 111 and.
//    reg_write=1, use_imm=0. funct7 must be 0000000, or 0100000 only for funct3 000/101.
//  - itype_op: same funct3 map, but never sub. For shifts, imm[11:5] must be 0000000 (sll/srl) or 0100000 (sra).
//    For shifts the imm is the shamt, zero-extended. I-immediate otherwise. use_imm=1, reg_write=1.
//  - ldtype_op: conf=add, I-imm, use_imm=1, is_load=1, reg_write=1.
//  - beq_op/bne_op: conf=sub, B-imm (bit0=0), rs1+rs2 used, is_branch=1, reg_write=0.
//  - jal_op/j_op: conf=add, J-imm, is_jump=1, reg_write=1 for jal only, rs1=rs2=0.
//  - cstype_op: conf=add, I-imm, is_system=1, reg_write=(rd!=0).
//  - funct3 010/011 (slt/sltu), any other opcode, or a bad funct7 -> illegal.
//    illegal=1, conf=add, reg_write/is_* = 0, rd=0. Still handshaked as a valid bundle.
//  - rd=0 with reg_write=1 is legal; reg_write is forced to 0.
//  - Reset asserted mid-stall clears out_valid immediately (async). No bundle survives.
// STRUCTURE
//  - Shared package additions: typedef enum imm_sel_t {IMM_I, IMM_SH, IMM_B, IMM_J, IMM_NONE}.
//    Also a packed struct id_bundle_t holding all out_* fields, reused by the EX stage input.
//  - Sub-module imm_gen: combinational (instr, imm_sel_t) -> DATA_W sign-extended immediate.
//  - The decode is an always_comb block building id_bundle_t. A single always_ff holds the bundle and out_valid.
// TESTING
//  - Reset then add x3,x1,x2 (0x002081B3), out_ready=1.
//    Next cycle: out_valid=1, conf=add, rs1=1, rs2=2, rd=3, reg_write=1, use_imm=0.
//  - sub 0x402081B3 -> conf=sub. addi x5,x0,-1 (0xFFF00293) -> imm=0xFFFFFFFF, use_imm=1, rd=5.
//  - srai x6,x7,3 (0x4033D313) -> conf=sra, imm=3. slt 0x003120B3 -> illegal=1, reg_write=0.
//  - Stall: hold out_ready=0 for 3 cycles with in_valid=1.
//    in_ready=0 throughout and out_* stable. On release, both instructions arrive in order, none lost or duplicated.
//  - flush with in_valid=1 and out_valid=1 -> next cycle out_valid=0. The following instruction is decoded normally.
//  - Back-to-back stream of 8 instructions with out_ready=1 -> 8 bundles on 8 consecutive cycles.
//    Assert rst_n low mid-stream -> out_valid=0 immediately.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// Shared RV32 decode types: opcodes, EX config codes, immediate selectors and the ID->EX bundle.
// Branches use the standard BRANCH opcode; funct3 000 is beq and 001 is bne. A plain jump is jal with rd=x0.
package decode_stage_pkg;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;
  localparam int DATA_W  = 32;
  localparam int RA_W    = 5;

  localparam logic [6:0] RTYPE_OP  = 7'b0110011;
  localparam logic [6:0] ITYPE_OP  = 7'b0010011;
  localparam logic [6:0] LDTYPE_OP = 7'b0000011;
  localparam logic [6:0] BRANCH_OP = 7'b1100011;
  localparam logic [6:0] JAL_OP    = 7'b1101111;
  localparam logic [6:0] CSTYPE_OP = 7'b1110011;

  localparam logic [2:0] BEQ_F3 = 3'b000;
  localparam logic [2:0] BNE_F3 = 3'b001;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    ADD_CONF = 3'd0,
    SUB_CONF = 3'd1,
    SLL_CONF = 3'd2,
    XOR_CONF = 3'd3,
    SRL_CONF = 3'd4,
    SRA_CONF = 3'd5,
    OR_CONF  = 3'd6,
    AND_CONF = 3'd7
  } iexu_conf_t;

  typedef enum logic [2:0] {IMM_I, IMM_SH, IMM_B, IMM_J, IMM_NONE} imm_sel_t;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [RA_W-1:0]   rs1;
    logic [RA_W-1:0]   rs2;
    logic [RA_W-1:0]   rd;
    logic [DATA_W-1:0] imm;
    iexu_conf_t        conf;
    logic              use_imm;
    logic              reg_write;
    logic              is_load;
    logic              is_branch;
    logic              is_jump;
    logic              is_system;
    logic              illegal;
  } id_bundle_t;

  // All-zero bundle; ADD_CONF encodes as 0 so this is also the reset config.
  localparam id_bundle_t BUNDLE_RST = '0;

  function automatic iexu_conf_t f3_conf(input logic [2:0] f3, input logic alt);
    iexu_conf_t c;
    c = ADD_CONF;
    case (f3)
      3'b000:  c = alt ? SUB_CONF : ADD_CONF;
      3'b001:  c = SLL_CONF;
      3'b100:  c = XOR_CONF;
      3'b101:  c = alt ? SRA_CONF : SRL_CONF;
      3'b110:  c = OR_CONF;
      3'b111:  c = AND_CONF;
      default: c = ADD_CONF;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch->ID and ID->EX handshakes. slave is the decode stage, master is the surrounding pipeline.
interface decode_stage_if;
  import decode_stage_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [INSTR_W-1:0]  in_instr;
  logic [PC_W-1:0]     in_pc;
  logic                out_valid;
  logic                out_ready;
  id_bundle_t          out_bundle;

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_bundle
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_bundle
  );
endinterface

// File: rtl/decode_stage_imm_gen.sv
// Immediate generator: combinational, zero latency, no flow control.
// Shift amounts are zero-extended; every other immediate is sign-extended from instr[31].
module imm_gen
  import decode_stage_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  input  imm_sel_t           sel,
  output logic [DATA_W-1:0]  imm
);

  logic unused_opc;
  assign unused_opc = ^instr[6:0];

  always_comb begin
    imm = '0;
    case (sel)
      IMM_I:   imm = {{(DATA_W-12){instr[31]}}, instr[31:20]};
      IMM_SH:  imm = {{(DATA_W-5){1'b0}}, instr[24:20]};
      IMM_B:   imm = {{(DATA_W-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J:   imm = {{(DATA_W-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV32 instruction decode stage: one pipeline register, 1-cycle latency.
// in_ready drops while a bundle is held and out_ready is low; flush kills held and incoming work.
module decode_stage
  import decode_stage_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  decode_stage_if.slave io
);

  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [RA_W-1:0] rs1_f, rs2_f, rd_f;
  logic            shift_op;
  logic            alu_f3_ok;
  logic            wr_req;
  imm_sel_t        imm_sel;
  logic [DATA_W-1:0] imm;
  id_bundle_t      dec, dec_nxt, bundle_q;
  logic            valid_q;
  logic            xfer;

  assign opc   = io.in_instr[6:0];
  assign f3    = io.in_instr[14:12];
  assign f7    = io.in_instr[31:25];
  assign rs1_f = io.in_instr[19:15];
  assign rs2_f = io.in_instr[24:20];
  assign rd_f  = io.in_instr[11:7];

  assign shift_op  = (f3 == 3'b001) || (f3 == 3'b101);
  assign alu_f3_ok = (f3 != 3'b010) && (f3 != 3'b011);

  imm_gen u_imm_gen (
    .instr (io.in_instr),
    .sel   (imm_sel),
    .imm   (imm)
  );

  always_comb begin
    dec     = BUNDLE_RST;
    imm_sel = IMM_NONE;
    wr_req  = 1'b0;
    case (opc)
      RTYPE_OP: begin
        if (alu_f3_ok && (f7 == F7_BASE ||
            (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)))) begin
          dec.conf = f3_conf(f3, f7[5]);
          dec.rs1  = rs1_f;
          dec.rs2  = rs2_f;
          wr_req   = 1'b1;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      ITYPE_OP: begin
        // imm[11:5] only qualifies shifts; addi with a negative imm must not turn into sub
        if (alu_f3_ok && (!shift_op || f7 == F7_BASE ||
            (f7 == F7_ALT && f3 == 3'b101))) begin
          dec.conf    = f3_conf(f3, shift_op & f7[5]);
          dec.rs1     = rs1_f;
          dec.use_imm = 1'b1;
          imm_sel     = shift_op ? IMM_SH : IMM_I;
          wr_req      = 1'b1;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      LDTYPE_OP: begin
        dec.rs1     = rs1_f;
        dec.use_imm = 1'b1;
        dec.is_load = 1'b1;
        imm_sel     = IMM_I;
        wr_req      = 1'b1;
      end
      BRANCH_OP: begin
        if (f3 == BEQ_F3 || f3 == BNE_F3) begin
          dec.conf      = SUB_CONF;
          dec.rs1       = rs1_f;
          dec.rs2       = rs2_f;
          dec.is_branch = 1'b1;
          imm_sel       = IMM_B;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      JAL_OP: begin
        dec.is_jump = 1'b1;
        imm_sel     = IMM_J;
        wr_req      = 1'b1;
      end
      CSTYPE_OP: begin
        dec.rs1       = rs1_f;
        dec.is_system = 1'b1;
        imm_sel       = IMM_I;
        wr_req        = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
    // Writes to x0 are architecturally dropped, so they never reach writeback
    if (wr_req && rd_f != '0) begin
      dec.reg_write = 1'b1;
      dec.rd        = rd_f;
    end
  end

  always_comb begin
    dec_nxt     = dec;
    dec_nxt.pc  = io.in_pc;
    dec_nxt.imm = imm;
  end

  assign io.in_ready = !valid_q || io.out_ready;
  assign xfer        = io.in_valid && io.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      bundle_q <= BUNDLE_RST;
    end else begin
      if (flush)
        valid_q <= 1'b0;
      else if (xfer)
        valid_q <= 1'b1;
      else if (io.out_ready)
        valid_q <= 1'b0;
      if (xfer && !flush)
        bundle_q <= dec_nxt;
    end
  end

  assign io.out_valid  = valid_q;
  assign io.out_bundle = bundle_q;

endmodule

// File: tb/tb_decode_stage.sv
// Randomized and directed bench for decode_stage against a field-level RV32 decode model.
module tb_decode_stage;
  import decode_stage_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  decode_stage_if io ();

  decode_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .io    (io)
  );

  int n_vec = 0;
  int n_bad = 0;
  int delivered = 0;

  bit         mvalid = 1'b0;
  id_bundle_t mb     = '0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic iexu_conf_t ref_conf(input logic [2:0] f3, input bit alt);
    iexu_conf_t tbl [8] = '{ADD_CONF, SLL_CONF, ADD_CONF, ADD_CONF,
                            XOR_CONF, SRL_CONF, OR_CONF, AND_CONF};
    if (alt && f3 == 3'd0) return SUB_CONF;
    if (alt && f3 == 3'd5) return SRA_CONF;
    return tbl[f3];
  endfunction

  function automatic id_bundle_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
    id_bundle_t  b;
    logic [2:0]  f3;
    logic [6:0]  f7;
    bit          alt, ok, wr, shift;
    int          imm_i, imm_b, imm_j;
    b     = '0;
    f3    = ins[14:12];
    f7    = ins[31:25];
    alt   = (f7 == 7'h20);
    shift = (f3 == 3'd1 || f3 == 3'd5);
    ok    = 1'b1;
    wr    = 1'b0;
    imm_i = $signed(ins) >>> 20;
    imm_b = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32
            + int'(ins[11:8]) * 2;
    imm_j = (ins[31] ? -(1 << 20) : 0) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048
            + int'(ins[30:21]) * 2;
    case (ins[6:0])
      7'h33: begin
        ok = (f3 != 3'd2 && f3 != 3'd3) && (f7 == 7'h00 || (alt && (f3 == 3'd0 || f3 == 3'd5)));
        b.conf = ref_conf(f3, alt);
        b.rs1 = ins[19:15];
        b.rs2 = ins[24:20];
        wr = 1'b1;
      end
      7'h13: begin
        ok = (f3 != 3'd2 && f3 != 3'd3) && (!shift || f7 == 7'h00 || (alt && f3 == 3'd5));
        b.conf = ref_conf(f3, alt && shift);
        if (shift) b.imm = 32'(ins[24:20]);
        else       b.imm = imm_i;
        b.use_imm = 1'b1;
        b.rs1 = ins[19:15];
        wr = 1'b1;
      end
      7'h03: begin
        b.imm = imm_i; b.use_imm = 1'b1; b.is_load = 1'b1; b.rs1 = ins[19:15]; wr = 1'b1;
      end
      7'h63: begin
        ok = (f3 < 3'd2);
        b.conf = SUB_CONF; b.imm = imm_b; b.is_branch = 1'b1;
        b.rs1 = ins[19:15]; b.rs2 = ins[24:20];
      end
      7'h6F: begin
        b.imm = imm_j; b.is_jump = 1'b1; wr = 1'b1;
      end
      7'h73: begin
        b.imm = imm_i; b.is_system = 1'b1; b.rs1 = ins[19:15]; wr = 1'b1;
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      b = '0;
      b.illegal = 1'b1;
    end else if (wr && ins[11:7] != 5'd0) begin
      b.reg_write = 1'b1;
      b.rd = ins[11:7];
    end
    b.pc = pc;
    return b;
  endfunction

  function automatic logic [6:0] pick_f7();
    case ($urandom_range(0, 3))
      0, 1:    return 7'h00;
      2:       return 7'h20;
      default: return 7'($urandom);
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [31:0] res;
    r = $urandom;
    case ($urandom_range(0, 7))
      0:       res = {pick_f7(), r[24:7], 7'h33};
      1:       res = {pick_f7(), r[24:7], 7'h13};
      2:       res = {r[31:7], 7'h03};
      3:       res = {r[31:15], ($urandom_range(0, 3) == 0 ? r[14:12] : {2'b00, r[12]}), r[11:7], 7'h63};
      4:       res = {r[31:7], 7'h6F};
      5:       res = {r[31:7], 7'h73};
      default: res = r;
    endcase
    return res;
  endfunction

  // Called at a falling edge; leaves at the next falling edge with the model advanced.
  task automatic cycle(input bit fl, input bit iv, input logic [31:0] ins,
                       input logic [31:0] pc, input bit ordy);
    check("out_valid", io.out_valid, mvalid);
    if (mvalid) check("bundle", io.out_bundle, mb);
    flush       = fl;
    io.in_valid = iv;
    io.in_instr = ins;
    io.in_pc    = pc;
    io.out_ready = ordy;
    #1;
    check("in_ready", io.in_ready, !mvalid || ordy);
    if (mvalid && ordy) delivered++;
    if (fl)
      mvalid = 1'b0;
    else if (iv && (!mvalid || ordy)) begin
      mvalid = 1'b1;
      mb = ref_decode(ins, pc);
    end else if (mvalid && ordy)
      mvalid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int cnt;
    int d0;
    io.in_valid  = 1'b0;
    io.in_instr  = '0;
    io.in_pc     = '0;
    io.out_ready = 1'b0;

    @(negedge clk);
    check("rst.out_valid", io.out_valid, 1'b0);
    check("rst.bundle", io.out_bundle, '0);
    check("rst.conf", io.out_bundle.conf, ADD_CONF);
    check("rst.in_ready", io.in_ready, 1'b1);
    rst_n = 1'b1;

    cycle(0, 1, 32'h002081B3, 32'h100, 1);
    check("add.valid", io.out_valid, 1'b1);
    check("add.conf", io.out_bundle.conf, ADD_CONF);
    check("add.rs1", io.out_bundle.rs1, 5'd1);
    check("add.rs2", io.out_bundle.rs2, 5'd2);
    check("add.rd", io.out_bundle.rd, 5'd3);
    check("add.reg_write", io.out_bundle.reg_write, 1'b1);
    check("add.use_imm", io.out_bundle.use_imm, 1'b0);

    cycle(0, 1, 32'h402081B3, 32'h104, 1);
    check("sub.conf", io.out_bundle.conf, SUB_CONF);
    cycle(0, 1, 32'hFFF00293, 32'h108, 1);
    check("addi.imm", io.out_bundle.imm, 32'hFFFF_FFFF);
    check("addi.use_imm", io.out_bundle.use_imm, 1'b1);
    check("addi.rd", io.out_bundle.rd, 5'd5);
    cycle(0, 1, 32'h4033D313, 32'h10C, 1);
    check("srai.conf", io.out_bundle.conf, SRA_CONF);
    check("srai.imm", io.out_bundle.imm, 32'd3);
    cycle(0, 1, 32'h003120B3, 32'h110, 1);
    check("slt.illegal", io.out_bundle.illegal, 1'b1);
    check("slt.reg_write", io.out_bundle.reg_write, 1'b0);
    cycle(0, 0, 32'h0, 32'h0, 1);

    // Stall with a second instruction waiting
    d0 = delivered;
    cycle(0, 1, 32'h00500093, 32'h200, 1);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 32'h00A00113, 32'h204, 0);
      check("stall.in_ready", io.in_ready, 1'b0);
      check("stall.pc", io.out_bundle.pc, 32'h200);
    end
    cycle(0, 1, 32'h00A00113, 32'h204, 1);
    check("stall.second_pc", io.out_bundle.pc, 32'h204);
    cycle(0, 0, 32'h0, 32'h0, 1);
    cycle(0, 0, 32'h0, 32'h0, 1);
    check("stall.delivered", delivered - d0, 2);

    // Flush against a held bundle and a waiting instruction
    cycle(0, 1, 32'h00108093, 32'h300, 0);
    cycle(1, 1, 32'h00210113, 32'h304, 0);
    check("flush.out_valid", io.out_valid, 1'b0);
    cycle(0, 1, 32'h00318193, 32'h308, 1);
    check("flush.next_pc", io.out_bundle.pc, 32'h308);
    cycle(0, 0, 32'h0, 32'h0, 1);

    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(0, 1, rand_instr(), 32'h400 + 32'(i * 4), 1);
      if (io.out_valid) cnt++;
    end
    check("b2b.count", cnt, 8);

    for (int i = 0; i < 600; i++)
      cycle(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0), rand_instr(),
            $urandom, ($urandom_range(0, 3) != 0));

    // Asynchronous reset in the middle of a stalled stream
    cycle(0, 1, 32'h00C00513, 32'h500, 0);
    cycle(0, 1, 32'h00D00593, 32'h504, 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst.out_valid", io.out_valid, 1'b0);
    check("arst.bundle", io.out_bundle, '0);
    mvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(0, 1, 32'h00E00613, 32'h600, 1);
    check("arst.recover_pc", io.out_bundle.pc, 32'h600);
    cycle(0, 0, 32'h0, 32'h0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
